muldiv_sequencer: RTL and testbench

//  Sequences the shared multiplier and divider units for MULT/DIV instructions.
//  The control unit issues one request. The block pulses the selected unit's start,

---
 rtl/muldiv_sequencer.sv | 136 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divider for MULT/DIV and commits results to HI/LO.
// Latency: Req sampled at edge k -> start pulse in cycle k+1; ready in WAIT cycle m -> HI/LO write in m+1.
// Backpressure: Req is accepted only while idle (never queued); MFHI/MFLO stall while an op is in flight.
//
// Ports:
//   clk_i, rst_ni                  clock (rising edge), asynchronous active-low reset
//   req_i, op_i                    issue request, 0 = MULT / 1 = DIV (sampled together in IDLE)
//   abort_i                        cancel the in-flight operation (exception/flush)
//   mult_ready_i, div_ready_i      unit result valid
//   div_zero_i                     divider reports divisor == 0
//   hilo_rd_i                      MFHI/MFLO wants HI/LO this cycle
//   mult_start_o, div_start_o      one-cycle unit start pulses
//   hi_wr_o, lo_wr_o, done_o       one-cycle commit pulses
//   busy_o                         operation in flight
//   div_zero_exc_o, timeout_o      one-cycle error pulses
//   stall_o                        hilo_rd_i & busy_o (combinational)
module muldiv_sequencer #(
  parameter int MAX_CYCLES = 64,
  parameter int CNT_W      = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic op_i,
  input  logic abort_i,
  input  logic mult_ready_i,
  input  logic div_ready_i,
  input  logic div_zero_i,
  input  logic hilo_rd_i,
  output logic mult_start_o,
  output logic div_start_o,
  output logic hi_wr_o,
  output logic lo_wr_o,
  output logic busy_o,
  output logic done_o,
  output logic div_zero_exc_o,
  output logic timeout_o,
  output logic stall_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_WB,
    S_DZERO,
    S_TOUT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             sel_ready;

  logic mult_start_q, div_start_q, wb_q, dzexc_q, tout_q, busy_q;

  // Only the unit that was actually launched may complete the operation.
  assign sel_ready = op_q ? div_ready_i : mult_ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          op_d    = op_i;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Priority: abort, divide-by-zero (DIV only), completion, timeout.
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (op_q && div_zero_i) begin
          state_d = S_DZERO;
        end else if (sel_ready) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB, S_DZERO, S_TOUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state, so each one is a pure
  // function of the registered state as seen by the outside world.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= 1'b0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      wb_q         <= 1'b0;
      dzexc_q      <= 1'b0;
      tout_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      mult_start_q <= (state_d == S_LAUNCH) && !op_d;
      div_start_q  <= (state_d == S_LAUNCH) && op_d;
      wb_q         <= (state_d == S_WB);
      dzexc_q      <= (state_d == S_DZERO);
      tout_q       <= (state_d == S_TOUT);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign mult_start_o   = mult_start_q;
  assign div_start_o    = div_start_q;
  assign hi_wr_o        = wb_q;
  assign lo_wr_o        = wb_q;
  assign done_o         = wb_q;
  assign div_zero_exc_o = dzexc_q;
  assign timeout_o      = tout_q;
  assign busy_o         = busy_q;
  assign stall_o        = hilo_rd_i & busy_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, op = 1'b0, abort = 1'b0;
  logic mult_ready = 1'b0, div_ready = 1'b0, div_zero = 1'b0, hilo_rd = 1'b0;
  logic mult_start, div_start, hi_wr, lo_wr, busy, done, dzexc, tout, stall;

  // Second instance with a short timeout window.
  logic req_b = 1'b0, op_b = 1'b0;
  logic mult_start_b, div_start_b, hi_wr_b, lo_wr_b, busy_b, done_b, dzexc_b, tout_b, stall_b;

  int n_cmp = 0;
  int n_err = 0;
  int bcnt, mscnt, wcnt;

  logic [8:0] outv;
  assign outv = {mult_start, div_start, hi_wr, lo_wr, busy, done, dzexc, tout, stall};

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_i(op), .abort_i(abort),
    .mult_ready_i(mult_ready), .div_ready_i(div_ready), .div_zero_i(div_zero),
    .hilo_rd_i(hilo_rd), .mult_start_o(mult_start), .div_start_o(div_start),
    .hi_wr_o(hi_wr), .lo_wr_o(lo_wr), .busy_o(busy), .done_o(done),
    .div_zero_exc_o(dzexc), .timeout_o(tout), .stall_o(stall)
  );

  muldiv_sequencer #(.MAX_CYCLES(8), .CNT_W(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .op_i(op_b), .abort_i(1'b0),
    .mult_ready_i(1'b0), .div_ready_i(1'b0), .div_zero_i(1'b0),
    .hilo_rd_i(1'b0), .mult_start_o(mult_start_b), .div_start_o(div_start_b),
    .hi_wr_o(hi_wr_b), .lo_wr_o(lo_wr_b), .busy_o(busy_b), .done_o(done_b),
    .div_zero_exc_o(dzexc_b), .timeout_o(tout_b), .stall_o(stall_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(outv), 32'h0);
    chk("reset_busy_b", 32'(busy_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'(outv), 32'h0);

    // ---------------- 1: MULT, ready in 32nd WAIT cycle ----------------
    req = 1'b1; op = 1'b0;
    tick();                                   // LAUNCH
    chk("t1_mult_start", 32'(mult_start), 32'h1);
    chk("t1_div_start", 32'(div_start), 32'h0);
    req = 1'b0;
    bcnt = int'(busy); mscnt = int'(mult_start); wcnt = int'(hi_wr);
    for (int i = 1; i <= 32; i++) begin
      tick();                                 // WAIT cycle i
      bcnt += int'(busy); mscnt += int'(mult_start); wcnt += int'(hi_wr);
      if (i == 32) mult_ready = 1'b1;
    end
    tick();                                   // WB
    chk("t1_wb_hilo_done", {29'h0, hi_wr, lo_wr, done}, 32'h7);
    bcnt += int'(busy); mscnt += int'(mult_start); wcnt += int'(hi_wr);
    mult_ready = 1'b0;
    tick();                                   // IDLE
    bcnt += int'(busy); wcnt += int'(hi_wr);
    chk("t1_idle_busy_done", {30'h0, busy, done}, 32'h0);
    chk("t1_busy_cycles", 32'(bcnt), 32'd34);
    chk("t1_mult_start_cycles", 32'(mscnt), 32'd1);
    chk("t1_hi_wr_cycles", 32'(wcnt), 32'd1);

    // ---------------- 2: DIV by zero ----------------
    req = 1'b1; op = 1'b1;
    tick();                                   // LAUNCH
    chk("t2_div_start", 32'(div_start), 32'h1);
    chk("t2_mult_start", 32'(mult_start), 32'h0);
    req = 1'b0; div_zero = 1'b1;
    tick();                                   // WAIT 1
    chk("t2_wait_no_exc", 32'(dzexc), 32'h0);
    tick();                                   // DZERO
    chk("t2_dzexc", 32'(dzexc), 32'h1);
    chk("t2_no_write", {30'h0, hi_wr, lo_wr}, 32'h0);
    chk("t2_no_done", 32'(done), 32'h0);
    div_zero = 1'b0;
    tick();                                   // IDLE
    chk("t2_idle", {30'h0, busy, dzexc}, 32'h0);

    // ---------------- 3: timeout on MAX_CYCLES=8 instance ----------------
    req_b = 1'b1; op_b = 1'b0;
    tick();                                   // LAUNCH
    chk("t3_mult_start_b", 32'(mult_start_b), 32'h1);
    req_b = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();                                 // WAIT cycle i
      chk("t3_wait_busy_tout", {30'h0, busy_b, tout_b}, 32'h2);
    end
    tick();                                   // TOUT
    chk("t3_timeout", 32'(tout_b), 32'h1);
    chk("t3_no_write", {29'h0, hi_wr_b, lo_wr_b, done_b}, 32'h0);
    tick();                                   // IDLE
    chk("t3_idle", {30'h0, busy_b, tout_b}, 32'h0);

    // ---------------- 4: abort beats ready ----------------
    req = 1'b1; op = 1'b0;
    tick();                                   // LAUNCH
    req = 1'b0;
    tick();                                   // WAIT 1
    tick();                                   // WAIT 2
    abort = 1'b1; mult_ready = 1'b1;
    tick();                                   // IDLE
    chk("t4_abort_idle", {29'h0, busy, hi_wr, done}, 32'h0);
    abort = 1'b0; mult_ready = 1'b0;
    tick();
    chk("t4_no_late_done", {30'h0, done, busy}, 32'h0);

    // 4b: divider signals ignored during MULT; abort ignored in IDLE
    req = 1'b1; op = 1'b0;
    tick();                                   // LAUNCH
    req = 1'b0; div_zero = 1'b1; div_ready = 1'b1;
    tick();                                   // WAIT 1
    tick();                                   // WAIT 2
    chk("t4b_still_busy", {29'h0, busy, dzexc, done}, 32'h4);
    div_zero = 1'b0; div_ready = 1'b0; mult_ready = 1'b1;
    tick();                                   // WB
    chk("t4b_done", 32'(done), 32'h1);
    mult_ready = 1'b0;
    tick();                                   // IDLE
    abort = 1'b1;
    tick();
    chk("t4b_abort_idle_noop", 32'(outv), 32'h0);
    abort = 1'b0;

    // ---------------- 5: stall, Req while busy, foreign ready ----------------
    req = 1'b1; op = 1'b1;
    tick();                                   // LAUNCH
    hilo_rd = 1'b1; mult_ready = 1'b1;        // req held high on purpose
    #1;
    chk("t5_stall", 32'(stall), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      tick();                                 // WAIT i
      chk("t5_no_restart", {29'h0, mult_start, div_start, done}, 32'h0);
      chk("t5_busy", 32'(busy), 32'h1);
    end
    req = 1'b0; mult_ready = 1'b0; div_ready = 1'b1;
    tick();                                   // WB
    chk("t5_wb", {30'h0, done, stall}, 32'h3);
    div_ready = 1'b0;
    req = 1'b1; op = 1'b0;                    // ignored in WB, taken in IDLE
    tick();                                   // IDLE
    chk("t5_idle_no_stall", {29'h0, busy, stall, mult_start}, 32'h0);
    tick();                                   // LAUNCH
    chk("t5_relaunch", 32'(mult_start), 32'h1);
    req = 1'b0; hilo_rd = 1'b0;
    tick();                                   // WAIT 1
    abort = 1'b1;
    tick();                                   // IDLE
    abort = 1'b0;
    chk("t5_cleanup_idle", 32'(busy), 32'h0);

    // ---------------- 6: async reset mid-WAIT ----------------
    req = 1'b1; op = 1'b0;
    tick();                                   // LAUNCH
    req = 1'b0; hilo_rd = 1'b1;
    tick();                                   // WAIT 1
    tick();                                   // WAIT 2
    chk("t6_pre_reset_stall", {30'h0, busy, stall}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_immediate", 32'(outv), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_reset_held", 32'(outv), 32'h0);
    rst_n = 1'b1; hilo_rd = 1'b0;
    req = 1'b1; op = 1'b0;
    tick();                                   // LAUNCH
    chk("t6_launch", {30'h0, mult_start, busy}, 32'h3);
    req = 1'b0; mult_ready = 1'b1;
    tick();                                   // WAIT 1
    chk("t6_wait_no_done", 32'(done), 32'h0);
    tick();                                   // WB: Req-to-Done = 3 cycles
    chk("t6_min_latency_done", 32'(done), 32'h1);
    mult_ready = 1'b0;
    tick();
    chk("t6_final_idle", 32'(outv), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
